// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner:
// the scan FSM state type, the active-low hex segment table (bits g..a)
// and the all-off segment pattern.
package seven_seg_scan_ctrl_pkg;

  // Scan phase inside one digit slot.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, bit order g f e d c b a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Indexed by the hex value; entry 0 sits in the lowest slice.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder (g..a).
module hex7seg_decode
  import seven_seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  // Table lookup; every input value has an entry, so no latch is possible.
  always_comb begin
    seg_n_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_n_o = SEG_HEX_0;
      4'h1: seg_n_o = SEG_HEX_1;
      4'h2: seg_n_o = SEG_HEX_2;
      4'h3: seg_n_o = SEG_HEX_3;
      4'h4: seg_n_o = SEG_HEX_4;
      4'h5: seg_n_o = SEG_HEX_5;
      4'h6: seg_n_o = SEG_HEX_6;
      4'h7: seg_n_o = SEG_HEX_7;
      4'h8: seg_n_o = SEG_HEX_8;
      4'h9: seg_n_o = SEG_HEX_9;
      4'hA: seg_n_o = SEG_HEX_A;
      4'hB: seg_n_o = SEG_HEX_B;
      4'hC: seg_n_o = SEG_HEX_C;
      4'hD: seg_n_o = SEG_HEX_D;
      4'hE: seg_n_o = SEG_HEX_E;
      4'hF: seg_n_o = SEG_HEX_F;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | dead time at the start of a digit slot, all anodes off
//   ST_DRIVE | remainder of the slot, current digit anode driven low
//
// A slot counter runs 0..CLK_DIV-1; each wrap advances the digit 0..3.
// New values are staged in a pending register and copied to the display
// register only at the frame boundary (digit 3, last slot cycle), so a
// frame is never shown half old, half new. All outputs are registered and
// lag the counter/FSM state by exactly one clock.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lzb,
  output logic [3:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam bit               HAS_DEAD  = (DEAD_CYCLES > 0);
  // With no dead time the slot starts directly in DRIVE.
  localparam scan_state_e      ST_INIT   = HAS_DEAD ? ST_BLANK : ST_DRIVE;

  // Scan position and FSM
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [1:0]       digit_q, digit_d;
  scan_state_e      state_q, state_d;

  // Pending (staging) and display registers
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_flag_q, pend_flag_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;

  // Output registers
  logic [3:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic       dpn_q, dpn_d;
  logic       fdone_q, fdone_d;

  logic       slot_wrap;
  logic       boundary;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic [3:0] nib_empty;
  logic [3:0] lz_blank;

  assign slot_wrap = (slot_q == CNT_LAST);
  assign boundary  = en && slot_wrap && (digit_q == 2'd3);

  // Slot counter and digit index; both held at zero while disabled.
  always_comb begin
    slot_d  = slot_q;
    digit_d = digit_q;
    if (!en) begin
      slot_d  = '0;
      digit_d = 2'd0;
    end else if (slot_wrap) begin
      slot_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      slot_d  = slot_q + CNT_W'(1);
    end
  end

  // Next-state logic: BLANK for the first DEAD_CYCLES of each slot, then DRIVE.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_INIT;
    end else begin
      unique case (state_q)
        ST_BLANK: if (slot_q == DEAD_LAST) state_d = ST_DRIVE;
        ST_DRIVE: if (HAS_DEAD && slot_wrap) state_d = ST_BLANK;
        default:  state_d = ST_INIT;
      endcase
    end
  end

  // Load staging and frame-boundary transfer. A load on the boundary edge
  // lands in pending only; the display takes the previous pending value.
  always_comb begin
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    if (boundary && pend_flag_q) begin
      disp_val_d  = pend_val_q;
      disp_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp;
      pend_flag_d = 1'b1;
    end
  end

  // Leading-zero mask: a digit is blankable when it and every higher digit
  // are zero with no decimal point lit. Digit 0 always shows.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib_empty[k] = (disp_val_q[4*k +: 4] == 4'h0) && !disp_dp_q[k];
    end
    lz_blank[3] = lzb && nib_empty[3];
    lz_blank[2] = lz_blank[3] && nib_empty[2];
    lz_blank[1] = lz_blank[2] && nib_empty[1];
    lz_blank[0] = 1'b0;
  end

  assign cur_nib = disp_val_q[{digit_q, 2'b00} +: 4];

  hex7seg_decode u_decode (
    .hex_i   (cur_nib),
    .seg_n_o (cur_seg)
  );

  // Output next values: blank by default, digit pattern only while driving.
  always_comb begin
    anode_d = 4'b1111;
    seg_d   = SEG_BLANK;
    dpn_d   = 1'b1;
    fdone_d = boundary;
    if (en && (state_q == ST_DRIVE) && !lz_blank[digit_q]) begin
      anode_d = ~(4'b0001 << digit_q);
      seg_d   = cur_seg;
      dpn_d   = ~disp_dp_q[digit_q];
    end
  end

  // State, data and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= '0;
      digit_q     <= 2'd0;
      state_q     <= ST_INIT;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      anode_q     <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dpn_q       <= 1'b1;
      fdone_q     <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      digit_q     <= digit_d;
      state_q     <= state_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dpn_q       <= dpn_d;
      fdone_q     <= fdone_d;
    end
  end

  assign anode_n    = anode_q;
  assign seg_n      = seg_q;
  assign dp_n       = dpn_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with CLK_DIV=8, DEAD_CYCLES=2.
// The reference model tracks elapsed enabled cycles as a single integer and
// derives slot/digit by division, with pending/display values as plain vars.
module tb_seven_seg_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset, en, load, lzb;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done;

  int vecs = 0;
  int miscompares = 0;

  // reference model state
  int          m_t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pflag;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dpn, e_fd;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] sg_tab [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  seven_seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .lzb        (lzb),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // One clock: the model computes what the outputs must show after this edge
  // from its pre-edge state and the inputs, then advances. Sampling is #1 later.
  task automatic step();
    int slot, dig;
    bit blank, all_zero;
    @(posedge clk);
    e_anode = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
    if (reset) begin
      m_t = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pflag = 0;
    end else if (!en) begin
      m_t = 0;
      if (load) begin m_pend = value; m_pdp = dp; m_pflag = 1; end
    end else begin
      slot  = m_t % CLK_DIV;
      dig   = (m_t / CLK_DIV) % 4;
      blank = (slot < DEAD);
      if (lzb && dig > 0) begin
        all_zero = 1;
        for (int j = dig; j < 4; j++)
          if (m_disp[4*j +: 4] != 4'h0 || m_ddp[j]) all_zero = 0;
        if (all_zero) blank = 1;
      end
      if (!blank) begin
        e_anode = ~(4'h1 << dig);
        e_seg   = ref_seg(m_disp[4*dig +: 4]);
        e_dpn   = ~m_ddp[dig];
      end
      e_fd = (m_t == FRAME - 1);
      if (e_fd && m_pflag) begin m_disp = m_pend; m_ddp = m_pdp; m_pflag = 0; end
      if (load) begin m_pend = value; m_pdp = dp; m_pflag = 1; end
      m_t = (m_t + 1) % FRAME;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; en = 0; load = 0; lzb = 0; value = 16'h0; dp = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL reset: got an=%b seg=%b dp=%b fd=%b, want 1111 1111111 1 0",
                 anode_n, seg_n, dp_n, frame_done);
      end
    end
    reset = 0;
  endtask

  task automatic test_basic_scan();
    int guard = 0;
    en = 1; value = 16'h1234; dp = 4'h0; load = 1;
    step(); load = 0;
    do begin
      step(); guard++;
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL basic_pre: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
    end while (!e_fd && guard < 100);
    for (int c = 0; c < FRAME; c++) begin
      logic [3:0] xa;
      logic [6:0] xs;
      step();
      xa = (c % CLK_DIV < DEAD) ? 4'b1111 : an_tab[c / CLK_DIV];
      xs = (c % CLK_DIV < DEAD) ? 7'b1111111 : sg_tab[c / CLK_DIV];
      vecs++;
      if ({anode_n, seg_n, dp_n} !== {xa, xs, 1'b1}) begin
        miscompares++;
        $display("FAIL basic_1234 c=%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                 c, anode_n, seg_n, dp_n, xa, xs);
      end
    end
  endtask

  task automatic test_midframe_load();
    bit seen_fd = 0;
    for (int i = 0; i < 10; i++) step();
    value = 16'hABCD; load = 1; step(); load = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL midframe: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
      if (anode_n == 4'b0111) begin
        vecs++;
        if (seg_n !== (seen_fd ? 7'b0001000 : 7'b1111001)) begin
          miscompares++;
          $display("FAIL midframe_digit3: got seg=%b want %b", seg_n,
                   seen_fd ? 7'b0001000 : 7'b1111001);
        end
      end
      if (e_fd) seen_fd = 1;
    end
  endtask

  task automatic test_last_load_wins();
    int guard = 0;
    do begin step(); guard++; end while (!e_fd && guard < 100);
    step(); step();
    value = 16'h1111; load = 1; step(); load = 0;
    for (int i = 0; i < 6; i++) step();
    value = 16'h2222; load = 1; step(); load = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL last_wins: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
      if (anode_n != 4'b1111) begin
        vecs++;
        if (seg_n === 7'b1111001) begin
          miscompares++;
          $display("FAIL last_wins_no1111: got seg=%b, digit 1 must never show", seg_n);
        end
      end
    end
  endtask

  task automatic test_lzb();
    int n_d1, n_d2, n_d3;
    lzb = 1; value = 16'h0005; dp = 4'b0000; load = 1; step(); load = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL lzb_0005: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
      if (m_disp == 16'h0005 && !m_pflag && anode_n == 4'b1110) begin
        vecs++;
        if (seg_n !== 7'b0010010) begin
          miscompares++;
          $display("FAIL lzb_digit0: got seg=%b want 0010010", seg_n);
        end
      end
    end
    dp = 4'b0100; load = 1; step(); load = 0; dp = 4'b0000;
    n_d1 = 0; n_d2 = 0; n_d3 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL lzb_dp: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
      if (anode_n == 4'b1101) n_d1++;
      if (anode_n == 4'b1011) n_d2++;
      if (anode_n == 4'b0111) n_d3++;
    end
    vecs++;
    if (n_d1 == 0 || n_d2 == 0 || n_d3 != 0) begin
      miscompares++;
      $display("FAIL lzb_dp_digits: got d1=%0d d2=%0d d3=%0d cycles, want d1>0 d2>0 d3=0",
               n_d1, n_d2, n_d3);
    end
    lzb = 0;
  endtask

  task automatic test_reset_mid_drive();
    int guard = 0;
    while (m_t != 2 * CLK_DIV + 4 && guard < 100) begin step(); guard++; end
    reset = 1; step(); reset = 0;
    vecs++;
    if ({anode_n, seg_n, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got an=%b seg=%b fd=%b want 1111 1111111 0",
               anode_n, seg_n, frame_done);
    end
    for (int i = 0; i < FRAME + 8; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL reset_resume i=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
    end
  endtask

  task automatic test_en_low_mid_drive();
    int guard = 0;
    value = 16'h5678; dp = 4'b0010; load = 1; step(); load = 0; dp = 4'h0;
    do begin step(); guard++; end while (!e_fd && guard < 100);
    guard = 0;
    while (m_t != 2 * CLK_DIV + 4 && guard < 100) begin step(); guard++; end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin value = 16'h9ABC; load = 1; end
      step(); load = 0;
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL en_low i=%0d: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                 i, anode_n, seg_n, dp_n, frame_done);
      end
    end
    en = 1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL en_resume i=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
    end
  endtask

  task automatic test_load_on_frame_done();
    int guard = 0;
    int first_k = -1;
    do begin step(); guard++; end while (!e_fd && guard < 100);
    vecs++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL fd_align: got frame_done=%b want 1", frame_done);
    end
    value = 16'h4321; load = 1; step(); load = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL load_on_fd k=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 k, anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
      if (first_k < 0 && anode_n == 4'b1110 && seg_n == 7'b1111001) first_k = k;
    end
    vecs++;
    if (first_k != FRAME + 2) begin
      miscompares++;
      $display("FAIL load_on_fd_latency: new digit first seen at %0d, want %0d", first_k, FRAME + 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 19) == 0);
      value = 16'($urandom);
      dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
      step();
      vecs++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e_anode, e_seg, e_dpn, e_fd}) begin
        miscompares++;
        $display("FAIL random i=%0d: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, anode_n, seg_n, dp_n, frame_done, e_anode, e_seg, e_dpn, e_fd);
      end
    end
    reset = 0; en = 1; load = 0;
  endtask

  initial begin
    m_t = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pflag = 0;
    test_reset();
    test_basic_scan();
    test_midframe_load();
    test_last_load_wins();
    test_lzb();
    test_reset_mid_drive();
    test_en_low_mid_drive();
    test_load_on_frame_done();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
